// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller in front of the data memory; range-checks
// the address and absorbs async or sync memory read latency. LSU_MISALIGN_CHECK_EN adds alignment errors.
package lsu_ctrl_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        TRPL = 2'd2,
        WORD = 2'd3
    } op_enum_dmem_size;
endpackage

module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_SYNC_READ = 0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_we,
    input  op_enum_dmem_size      lsu_size,
    input  logic                  lsu_zero_ex,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic                  mem_zero_ex,
    output op_enum_dmem_size      mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  we_q;
    logic                  accept;
    logic                  capture;
    logic                  range_err;
    logic                  misalign;
    logic                  chk_err;
    logic [2:0]            nbytes;
    logic [ADDR_WIDTH:0]   end_addr;

    // One extra bit on the end address so addr + nbytes cannot wrap past zero.
    always_comb begin
        nbytes    = {1'b0, lsu_size} + 3'd1;
        end_addr  = {1'b0, lsu_addr} + (ADDR_WIDTH+1)'(nbytes);
        range_err = end_addr > (ADDR_WIDTH+1)'(DEPTH);
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (lsu_size)
            HALF:    misalign = lsu_addr[0];
            TRPL:    misalign = &lsu_addr[1:0];
            WORD:    misalign = |lsu_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign chk_err = range_err | misalign;
    assign accept  = lsu_valid & (state == IDLE);
    assign capture = ((state == ACCESS) & ~we_q & (MEM_SYNC_READ == 0)) | (state == WAIT);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lsu_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        case (state)
            IDLE: begin
                lsu_ready = ~res;
                if (lsu_valid) begin
                    state_nxt = chk_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_wen   = we_q;
                mem_ren   = ~we_q;
                state_nxt = (~we_q && (MEM_SYNC_READ != 0)) ? WAIT : RESP;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields stay held through RESP: the memory extends read data from mem_size.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            we_q        <= 1'b0;
            mem_size    <= BYTE;
            mem_zero_ex <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else if (accept) begin
            we_q        <= lsu_we;
            mem_size    <= lsu_size;
            mem_zero_ex <= lsu_zero_ex;
            mem_addr    <= lsu_addr;
            mem_wr_data <= lsu_wdata;
            rsp_rdata   <= '0;
            rsp_err     <= chk_err;
        end else if (capture) begin
            rsp_rdata   <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: one async-read and one sync-read instance, each with a byte memory model.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    typedef struct {
        int               dut;
        logic             we;
        op_enum_dmem_size size;
        logic             zx;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic             err;
        logic [31:0]      rdata;
        int               lat;
        int               hold;
        logic             early;
    } vec_t;

    logic             clk;
    logic             res;
    logic             lsu_valid   [2];
    logic             lsu_ready   [2];
    logic             lsu_we      [2];
    op_enum_dmem_size lsu_size    [2];
    logic             lsu_zero_ex [2];
    logic [31:0]      lsu_addr    [2];
    logic [31:0]      lsu_wdata   [2];
    logic             rsp_valid   [2];
    logic             rsp_ready   [2];
    logic [31:0]      rsp_rdata   [2];
    logic             rsp_err     [2];
    logic             mem_req     [2];
    logic             mem_wen     [2];
    logic             mem_ren     [2];
    logic             mem_zero_ex [2];
    op_enum_dmem_size mem_size    [2];
    logic [31:0]      mem_addr    [2];
    logic [31:0]      mem_wr_data [2];
    logic [31:0]      rd0;
    logic [31:0]      rd1_q;
    logic [7:0]       mem [2][16];

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb[$];
    vec_t tbl[$];

    lsu_ctrl #(.DEPTH(16), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SYNC_READ(0)) dut_async (
        .clk(clk), .res(res),
        .lsu_valid(lsu_valid[0]), .lsu_ready(lsu_ready[0]), .lsu_we(lsu_we[0]),
        .lsu_size(lsu_size[0]), .lsu_zero_ex(lsu_zero_ex[0]), .lsu_addr(lsu_addr[0]),
        .lsu_wdata(lsu_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .mem_req(mem_req[0]),
        .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]), .mem_zero_ex(mem_zero_ex[0]),
        .mem_size(mem_size[0]), .mem_addr(mem_addr[0]), .mem_wr_data(mem_wr_data[0]),
        .mem_rd_data(rd0)
    );

    lsu_ctrl #(.DEPTH(16), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SYNC_READ(1)) dut_sync (
        .clk(clk), .res(res),
        .lsu_valid(lsu_valid[1]), .lsu_ready(lsu_ready[1]), .lsu_we(lsu_we[1]),
        .lsu_size(lsu_size[1]), .lsu_zero_ex(lsu_zero_ex[1]), .lsu_addr(lsu_addr[1]),
        .lsu_wdata(lsu_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .mem_req(mem_req[1]),
        .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]), .mem_zero_ex(mem_zero_ex[1]),
        .mem_size(mem_size[1]), .mem_addr(mem_addr[1]), .mem_wr_data(mem_wr_data[1]),
        .mem_rd_data(rd1_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian byte memory that extends read data from the requested size.
    function automatic logic [31:0] rd_ext(input int m, input logic [31:0] a,
                                           input op_enum_dmem_size s, input logic zx);
        logic [31:0] v;
        int          n;
        n = int'(s) + 1;
        v = '0;
        for (int i = 0; i < 4; i++)
            if (i < n) v[8*i +: 8] = mem[m][a[3:0] + 4'(i)];
        if (!zx && v[8*n-1])
            for (int i = 0; i < 4; i++)
                if (i >= n) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    always_comb rd0 = rd_ext(0, mem_addr[0], mem_size[0], mem_zero_ex[0]);

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++)
            if (!res && mem_req[m] && mem_wen[m])
                for (int i = 0; i < 4; i++)
                    if (i <= int'(mem_size[m]))
                        mem[m][mem_addr[m][3:0] + 4'(i)] <= mem_wr_data[m][8*i +: 8];
        if (mem_req[1] && mem_ren[1])
            rd1_q <= rd_ext(1, mem_addr[1], mem_size[1], mem_zero_ex[1]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic we, input op_enum_dmem_size s,
                                input logic zx, input logic [31:0] a, input logic [31:0] wd,
                                input logic err, input logic [31:0] rd, input int lat,
                                input int hold, input logic early);
        vec_t v;
        v.dut = d; v.we = we; v.size = s; v.zx = zx; v.addr = a; v.wdata = wd;
        v.err = err; v.rdata = rd; v.lat = lat; v.hold = hold; v.early = early;
        return v;
    endfunction

    task automatic txn(input vec_t v, input string tag);
        int   d;
        int   lat;
        int   reqs;
        logic got;
        vec_t e;
        d = v.dut;
        lsu_we[d]      = v.we;
        lsu_size[d]    = v.size;
        lsu_zero_ex[d] = v.zx;
        lsu_addr[d]    = v.addr;
        lsu_wdata[d]   = v.wdata;
        lsu_valid[d]   = 1'b1;
        sb.push_back(v);
        chk({tag, " ready_idle"}, 32'(lsu_ready[d]), 32'd1);
        if (v.early) rsp_ready[d] = 1'b1;
        lat  = 0;
        reqs = 0;
        got  = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) lsu_valid[d] = 1'b0;
            if (rsp_valid[d]) got = 1'b1;
            else reqs += int'(mem_req[d]);
        end
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no rsp_valid within %0d cycles, expected %0d", tag, lat, e.lat);
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(e.lat));
            chk({tag, " rsp_err"}, 32'(rsp_err[d]), 32'(e.err));
            chk({tag, " rsp_rdata"}, rsp_rdata[d], e.rdata);
            chk({tag, " mem_req_cycles"}, 32'(reqs), e.err ? 32'd0 : 32'd1);
            chk({tag, " mem_addr_held"}, mem_addr[d], e.addr);
            for (int i = 0; i < e.hold; i++) begin
                @(posedge clk);
                #1;
                chk({tag, " hold_valid"}, 32'(rsp_valid[d]), 32'd1);
                chk({tag, " hold_rdata"}, rsp_rdata[d], e.rdata);
                chk({tag, " hold_not_ready"}, 32'(lsu_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready[d] = 1'b0;
            chk({tag, " valid_dropped"}, 32'(rsp_valid[d]), 32'd0);
            chk({tag, " back_to_idle"}, 32'(lsu_ready[d]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic mis;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = 1'b1;
`else
        mis = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            lsu_valid[d] = 1'b0; lsu_we[d] = 1'b0; lsu_size[d] = BYTE; lsu_zero_ex[d] = 1'b0;
            lsu_addr[d] = '0; lsu_wdata[d] = '0; rsp_ready[d] = 1'b0;
        end
        //              dut we size zx addr          wdata         err rdata         lat hold early
        tbl.push_back(mk(0, 1, WORD, 0, 32'h4,        32'hDEADBEEF, 0, 32'h0,        2, 0, 0));
        tbl.push_back(mk(0, 0, WORD, 0, 32'h4,        32'h0,        0, 32'hDEADBEEF, 2, 5, 0));
        tbl.push_back(mk(0, 0, BYTE, 0, 32'h7,        32'h0,        0, 32'hFFFFFFDE, 2, 0, 1));
        tbl.push_back(mk(0, 0, BYTE, 1, 32'h7,        32'h0,        0, 32'h000000DE, 2, 0, 0));
        tbl.push_back(mk(0, 0, WORD, 0, 32'hD,        32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, HALF, 0, 32'h4,        32'h0,        0, 32'hFFFFBEEF, 2, 0, 0));
        tbl.push_back(mk(0, 0, TRPL, 1, 32'h5,        32'h0,        0, 32'h00DEADBE, 2, 0, 0));
        tbl.push_back(mk(0, 1, WORD, 0, 32'hC,        32'h80FF0102, 0, 32'h0,        2, 0, 0));
        tbl.push_back(mk(0, 0, WORD, 0, 32'hC,        32'h0,        0, 32'h80FF0102, 2, 0, 0));
        tbl.push_back(mk(0, 1, HALF, 0, 32'hF,        32'h1234,     1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, BYTE, 0, 32'hF,        32'h0,        0, 32'hFFFFFF80, 2, 0, 0));
        tbl.push_back(mk(0, 0, WORD, 0, 32'hFFFFFFFE, 32'h0,        1, 32'h0,        1, 0, 0));
        if (mis) tbl.push_back(mk(0, 0, HALF, 0, 32'h5, 32'h0, 1, 32'h0,        1, 0, 0));
        else     tbl.push_back(mk(0, 0, HALF, 0, 32'h5, 32'h0, 0, 32'hFFFFADBE, 2, 0, 0));
        tbl.push_back(mk(1, 1, WORD, 0, 32'h4,        32'hDEADBEEF, 0, 32'h0,        2, 0, 0));
        tbl.push_back(mk(1, 0, HALF, 0, 32'h4,        32'h0,        0, 32'hFFFFBEEF, 3, 0, 0));
        tbl.push_back(mk(1, 0, WORD, 0, 32'h4,        32'h0,        0, 32'hDEADBEEF, 3, 0, 1));
        tbl.push_back(mk(1, 0, WORD, 0, 32'hD,        32'h0,        1, 32'h0,        1, 0, 0));

        // Reset with a request pending: it must be ignored and all outputs idle.
        res = 1'b1;
        lsu_we[0] = 1'b1; lsu_size[0] = WORD; lsu_addr[0] = 32'h4; lsu_wdata[0] = 32'hCAFEF00D;
        lsu_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst lsu_ready", 32'(lsu_ready[0]), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst rsp_rdata", rsp_rdata[0], 32'd0);
        chk("rst rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rst mem_req", 32'(mem_req[0]), 32'd0);
        chk("rst mem_addr", mem_addr[0], 32'd0);
        chk("rst mem_wr_data", mem_wr_data[0], 32'd0);
        lsu_valid[0] = 1'b0;
        res = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst ready0", 32'(lsu_ready[0]), 32'd1);
        chk("post_rst ready1", 32'(lsu_ready[1]), 32'd1);
        chk("post_rst mem_req", 32'(mem_req[0]), 32'd0);

        for (int i = 0; i < tbl.size(); i++)
            txn(tbl[i], $sformatf("vec%0d", i));

        // Reset during the ACCESS cycle of a store drops the write.
        txn(mk(0, 1, WORD, 0, 32'h0, 32'hA5A5A5A5, 0, 32'h0, 2, 0, 0), "preload");
        lsu_we[0] = 1'b1; lsu_size[0] = BYTE; lsu_zero_ex[0] = 1'b0;
        lsu_addr[0] = 32'h2; lsu_wdata[0] = 32'h11; lsu_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        lsu_valid[0] = 1'b0;
        chk("midrst in_access mem_wen", 32'(mem_wen[0]), 32'd1);
        res = 1'b1;
        #1;
        chk("midrst lsu_ready", 32'(lsu_ready[0]), 32'd0);
        chk("midrst mem_req", 32'(mem_req[0]), 32'd0);
        chk("midrst mem_wen", 32'(mem_wen[0]), 32'd0);
        chk("midrst mem_addr", mem_addr[0], 32'd0);
        chk("midrst mem_wr_data", mem_wr_data[0], 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst ready_after", 32'(lsu_ready[0]), 32'd1);
        txn(mk(0, 0, BYTE, 1, 32'h2, 32'h0, 0, 32'h000000A5, 2, 0, 0), "old_contents");
        if (mis) txn(mk(0, 0, HALF, 0, 32'h1, 32'h0, 1, 32'h0,        1, 0, 0), "half_at_1");
        else     txn(mk(0, 0, HALF, 0, 32'h1, 32'h0, 0, 32'hFFFFA5A5, 2, 0, 0), "half_at_1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
